// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: pad synchronisers, per-pin debounce, edge/level
// event detection, a W1C pending register and a req/ack register port.
module gpio_irq_ctrl #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PINS-1:0] pin_i,
    input  logic                reg_req_i,
    input  logic                reg_we_i,
    input  logic [2:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_ack_o,
    output logic                irq_o
);
    localparam logic [2:0] ADDR_EN    = 3'd0;
    localparam logic [2:0] ADDR_TYPE  = 3'd1;
    localparam logic [2:0] ADDR_POL   = 3'd2;
    localparam logic [2:0] ADDR_BOTH  = 3'd3;
    localparam logic [2:0] ADDR_PEND  = 3'd4;
    localparam logic [2:0] ADDR_STATE = 3'd5;
    localparam logic [2:0] ADDR_DEB   = 3'd6;

    logic [NUM_PINS-1:0]  r_en;
    logic [NUM_PINS-1:0]  r_type;
    logic [NUM_PINS-1:0]  r_pol;
    logic [NUM_PINS-1:0]  r_both;
    logic [NUM_PINS-1:0]  r_pend;
    logic [NUM_PINS-1:0]  r_stable_d;
    logic [DEB_CNT_W-1:0] r_deb_limit;
    logic                 r_ack;
    logic                 r_irq;
    logic [31:0]          r_rdata;

    logic [NUM_PINS-1:0]  w_stable;
    logic [NUM_PINS-1:0]  w_rise;
    logic [NUM_PINS-1:0]  w_fall;
    logic [NUM_PINS-1:0]  w_edge_ev;
    logic [NUM_PINS-1:0]  w_lvl_ev;
    logic [NUM_PINS-1:0]  w_ev;
    logic [NUM_PINS-1:0]  w_clr;
    logic [NUM_PINS-1:0]  w_wdata;
    logic                 w_acc;
    logic                 w_wr;
    logic                 w_rd;
    logic [31:0]          w_rd_val;
    logic [DEB_CNT_W:0]   w_deb_thresh;
    logic                 w_unused_wdata;

    // Counter is one bit wider than DEB_LIMIT so the threshold L+1 never wraps.
    assign w_deb_thresh = {1'b0, r_deb_limit} + {{DEB_CNT_W{1'b0}}, 1'b1};

    generate
        for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] r_sync;
            logic [DEB_CNT_W:0]     r_cnt;
            logic                   r_stable;
            logic                   w_sync;

            assign w_sync       = r_sync[SYNC_STAGES-1];
            assign w_stable[gi] = r_stable;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync   <= '0;
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i[gi]};
                    if (w_sync != r_stable) begin
                        // >= so a lowered DEB_LIMIT releases an already-long count
                        if (r_cnt >= w_deb_thresh) begin
                            r_stable <= w_sync;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end
        end
    endgenerate

    assign w_rise    = w_stable & ~r_stable_d;
    assign w_fall    = ~w_stable & r_stable_d;
    assign w_edge_ev = (r_both & (w_rise | w_fall)) |
                       (~r_both & ((r_pol & w_rise) | (~r_pol & w_fall)));
    assign w_lvl_ev  = ~(w_stable ^ r_pol);
    assign w_ev      = (r_type & w_lvl_ev) | (~r_type & w_edge_ev);

    assign w_acc          = reg_req_i & ~r_ack;
    assign w_wr           = w_acc & reg_we_i;
    assign w_rd           = w_acc & ~reg_we_i;
    assign w_wdata        = reg_wdata_i[NUM_PINS-1:0];
    assign w_clr          = (w_wr && reg_addr_i == ADDR_PEND) ? w_wdata : '0;
    assign w_unused_wdata = ^reg_wdata_i;

    always_comb begin
        w_rd_val = '0;
        if (w_rd) begin
            case (reg_addr_i)
                ADDR_EN:    w_rd_val[NUM_PINS-1:0]  = r_en;
                ADDR_TYPE:  w_rd_val[NUM_PINS-1:0]  = r_type;
                ADDR_POL:   w_rd_val[NUM_PINS-1:0]  = r_pol;
                ADDR_BOTH:  w_rd_val[NUM_PINS-1:0]  = r_both;
                ADDR_PEND:  w_rd_val[NUM_PINS-1:0]  = r_pend;
                ADDR_STATE: w_rd_val[NUM_PINS-1:0]  = w_stable;
                ADDR_DEB:   w_rd_val[DEB_CNT_W-1:0] = r_deb_limit;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en        <= '0;
            r_type      <= '0;
            r_pol       <= '0;
            r_both      <= '0;
            r_pend      <= '0;
            r_stable_d  <= '0;
            r_deb_limit <= '0;
            r_ack       <= 1'b0;
            r_irq       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_ack      <= w_acc;
            r_rdata    <= w_rd_val;
            r_stable_d <= w_stable;
            // A new event on the same edge as its W1C keeps the bit set
            r_pend     <= (r_pend & ~w_clr) | (w_ev & r_en);
            r_irq      <= |(r_pend & r_en);
            if (w_wr) begin
                case (reg_addr_i)
                    ADDR_EN:   r_en        <= w_wdata;
                    ADDR_TYPE: r_type      <= w_wdata;
                    ADDR_POL:  r_pol       <= w_wdata;
                    ADDR_BOTH: r_both      <= w_wdata;
                    ADDR_DEB:  r_deb_limit <= reg_wdata_i[DEB_CNT_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    assign reg_ack_o   = r_ack;
    assign reg_rdata_o = r_rdata;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: a behavioural model predicts register
// reads and irq_o; a negedge monitor compares whenever the DUT acknowledges.
module tb_gpio_irq_ctrl;
    localparam int NP = 8;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pin_i;
    logic        req, we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] reg_rdata_o;
    logic        reg_ack_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_irq_ctrl #(.NUM_PINS(NP), .SYNC_STAGES(SS), .DEB_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .pin_i(pin_i),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_rdata_o(reg_rdata_o), .reg_ack_o(reg_ack_o), .irq_o(irq_o)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit [7:0] m_en, m_type, m_pol, m_both, m_pend, m_stable, m_prev;
    bit [3:0] m_lim;
    bit       m_ack, m_irq;
    bit [7:0] m_hist[SS];
    int       m_run[NP];
    bit [7:0] mv_sync, mv_ev, mv_clr;
    bit       mv_acc, mv_irq;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_en};
            3'd1: return {24'd0, m_type};
            3'd2: return {24'd0, m_pol};
            3'd3: return {24'd0, m_both};
            3'd4: return {24'd0, m_pend};
            3'd5: return {24'd0, m_stable};
            3'd6: return {28'd0, m_lim};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en = 0; m_type = 0; m_pol = 0; m_both = 0; m_pend = 0;
            m_stable = 0; m_prev = 0; m_lim = 0; m_ack = 0; m_irq = 0;
            for (int k = 0; k < SS; k++) m_hist[k] = 0;
            for (int p = 0; p < NP; p++) m_run[p] = 0;
            sb_q.delete();
        end else begin
            // pad value seen by the debouncer is the one sampled SS edges ago
            mv_sync = m_hist[SS-1];
            for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pin_i;

            for (int p = 0; p < NP; p++) begin
                if (m_type[p])                    mv_ev[p] = (m_stable[p] == m_pol[p]);
                else if (m_stable[p] == m_prev[p]) mv_ev[p] = 1'b0;
                else if (m_both[p])               mv_ev[p] = 1'b1;
                else                              mv_ev[p] = (m_stable[p] == m_pol[p]);
            end

            mv_acc = req && !m_ack;
            mv_clr = (mv_acc && we && addr == 3'd4) ? wdata[7:0] : 8'd0;
            if (mv_acc) sb_q.push_back('{is_rd: !we, val: m_read(addr)});

            mv_irq = |(m_pend & m_en);
            m_pend = (m_pend & ~mv_clr) | (mv_ev & m_en);
            m_prev = m_stable;

            // stable follows once the synced pad disagrees for L+2 samples
            for (int p = 0; p < NP; p++) begin
                if (mv_sync[p] != m_stable[p]) begin
                    m_run[p]++;
                    if (m_run[p] >= int'(m_lim) + 2) begin
                        m_stable[p] = mv_sync[p];
                        m_run[p]    = 0;
                    end
                end else begin
                    m_run[p] = 0;
                end
            end

            if (mv_acc && we) begin
                case (addr)
                    3'd0: m_en   = wdata[7:0];
                    3'd1: m_type = wdata[7:0];
                    3'd2: m_pol  = wdata[7:0];
                    3'd3: m_both = wdata[7:0];
                    3'd6: m_lim  = wdata[3:0];
                    default: ;
                endcase
            end
            m_ack = mv_acc;
            m_irq = mv_irq;
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("irq_o", irq_o, m_irq);
            if (reg_ack_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_rd) chk("rdata", reg_rdata_o, mon_e.val);
                end
            end else begin
                chk("rdata_idle", reg_rdata_o, 0);
                if (sb_q.size() != 0) begin
                    chk("missing_ack", 0, 1);
                    sb_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge where the ack is seen.
    task automatic reg_acc(input bit w, input logic [2:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
        bit got;
        req = 1'b1; we = w; addr = a; wdata = d;
        got = 1'b0;
        rd  = '0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (reg_ack_o) begin
                got = 1'b1;
                rd  = reg_rdata_o;
                break;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        req = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        reg_acc(1'b1, a, d, dummy);
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] rd);
        reg_acc(1'b0, a, 32'd0, rd);
    endtask

    task automatic irq_latency(output int lat);
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (irq_o && lat < 0) lat = c;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, acks;
        rst_n = 1'b0; pin_i = 8'hFF; req = 0; we = 0; addr = 0; wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", reg_ack_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rdata", reg_rdata_o, 0);
        rst_n = 1'b1;

        // 1: pads high out of reset, EN=0
        repeat (4) @(negedge clk);
        reg_rd(3'd5, rd); chk("t1_state", rd, 32'hFF);
        reg_rd(3'd4, rd); chk("t1_pend", rd, 32'h0);
        chk("t1_irq", irq_o, 0);

        // 2: rising edge on pin0, L=0
        pin_i = 8'h00;
        reg_wr(3'd6, 0); reg_wr(3'd1, 0); reg_wr(3'd2, 1); reg_wr(3'd3, 0);
        repeat (8) @(negedge clk);
        reg_wr(3'd4, 32'hFF); reg_wr(3'd0, 1);
        pin_i[0] = 1'b1;
        irq_latency(lat); chk("t2_irq_latency", lat, 5);
        reg_rd(3'd4, rd); chk("t2_pend", rd, 32'h1);
        reg_wr(3'd4, 1);
        repeat (2) @(negedge clk);
        chk("t2_irq_cleared", irq_o, 0);

        // 3: debounce L=3, any-edge on pin1
        reg_wr(3'd0, 0); reg_wr(3'd6, 3); reg_wr(3'd3, 2);
        reg_wr(3'd4, 32'hFF); reg_wr(3'd0, 2);
        pin_i[1] = 1'b1; repeat (3) @(negedge clk); pin_i[1] = 1'b0;
        repeat (12) @(negedge clk);
        reg_rd(3'd4, rd); chk("t3_glitch_pend", rd, 32'h0);
        pin_i[1] = 1'b1;
        irq_latency(lat); chk("t3_irq_latency", lat, 8);
        reg_rd(3'd4, rd); chk("t3_rise_pend", rd, 32'h2);
        reg_wr(3'd4, 2);
        pin_i[1] = 1'b0;
        repeat (12) @(negedge clk);
        reg_rd(3'd4, rd); chk("t3_fall_pend", rd, 32'h2);

        // 4: active-low level on pin2
        reg_wr(3'd0, 0); reg_wr(3'd1, 4); reg_wr(3'd2, 0);
        reg_wr(3'd4, 32'hFF); pin_i[2] = 1'b0; reg_wr(3'd0, 4);
        repeat (2) @(negedge clk);
        reg_wr(3'd4, 4);
        reg_rd(3'd4, rd); chk("t4_repend", rd, 32'h4);
        pin_i[2] = 1'b1;
        repeat (12) @(negedge clk);
        reg_wr(3'd4, 4);
        reg_rd(3'd4, rd); chk("t4_inactive_clear", rd, 32'h0);
        chk("t4_irq", irq_o, 0);

        // 5: W1C on the same edge as a new edge event
        reg_wr(3'd0, 0); reg_wr(3'd1, 0); reg_wr(3'd2, 1); reg_wr(3'd3, 0); reg_wr(3'd6, 0);
        pin_i[0] = 1'b0;
        repeat (8) @(negedge clk);
        reg_wr(3'd4, 32'hFF); reg_wr(3'd0, 1);
        pin_i[0] = 1'b1;
        repeat (4) @(negedge clk);
        reg_wr(3'd4, 1);
        reg_rd(3'd4, rd); chk("t5_set_wins", rd, 32'h1);

        // 6: reserved/ro addresses, held request, reset mid-access
        reg_rd(3'd7, rd); chk("t6_reserved", rd, 32'h0);
        pin_i = 8'hA5;
        repeat (10) @(negedge clk);
        reg_wr(3'd5, 0);
        reg_rd(3'd5, rd); chk("t6_state_ro", rd, 32'hA5);
        req = 1'b1; we = 1'b0; addr = 3'd0; acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (reg_ack_o) acks++;
        end
        req = 1'b0;
        chk("t6_held_req_acks", acks, 2);
        reg_wr(3'd0, 0); reg_wr(3'd1, 4); reg_wr(3'd2, 0);
        pin_i[2] = 1'b0; reg_wr(3'd0, 4);
        repeat (10) @(negedge clk);
        chk("t6_irq_before_rst", irq_o, 1);
        req = 1'b1; we = 1'b0; addr = 3'd4;
        @(posedge clk); #1;
        chk("t6_ack_before_rst", reg_ack_o, 1);
        rst_n = 1'b0; #1;
        chk("t6_rst_ack", reg_ack_o, 0);
        chk("t6_rst_irq", irq_o, 0);
        chk("t6_rst_rdata", reg_rdata_o, 0);
        @(negedge clk); req = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        reg_rd(3'd4, rd); chk("t6_rst_pend", rd, 32'h0);

        // randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            logic [2:0]  ra;
            logic [31:0] rdv;
            if ($urandom_range(0, 1) == 1) pin_i = pin_i ^ 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            ra = 3'($urandom);
            rdv = $urandom;
            if (ra == 3'd6) rdv = $urandom_range(0, 4);
            reg_acc(1'($urandom), ra, rdv, rd);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
